// File: rtl/shift_pipe_if.sv
// Request/response bundle for the pipelined barrel shifter.
// The slave side is the shifter; the master side is the issuing sequencer.
interface shift_pipe_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHIFT_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHIFT_W-1:0] in_shift;
  logic [2:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shift, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SHL/SHR/SRA/ROL/ROR) with valid/ready on both sides.
// Each stage resolves LEVELS_PER_STAGE power-of-two levels; bubbles collapse under backpressure.
module shift_pipe #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned SHIFT_W          = 32,
  parameter int unsigned LEVELS_PER_STAGE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  shift_pipe_if.slave bus,
  output logic        busy
);
  localparam int unsigned LG     = $clog2(WIDTH);
  localparam int unsigned NSTAGE = (LG + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  // Residual shift field is padded so every stage can index its levels without range checks.
  localparam int unsigned SHW    = NSTAGE * LEVELS_PER_STAGE;

  localparam logic [2:0] OpShl = 3'd0;
  localparam logic [2:0] OpShr = 3'd1;
  localparam logic [2:0] OpSra = 3'd2;
  localparam logic [2:0] OpRol = 3'd3;
  localparam logic [2:0] OpRor = 3'd4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic [2:0]       op;
    logic             oob;
    logic             sign;
  } entry_t;

  function automatic logic [WIDTH-1:0] shift_level(logic [WIDTH-1:0] d, logic [2:0] op,
                                                   logic sign, int unsigned amt);
    logic [WIDTH-1:0] res;
    case (op)
      OpShl:   res = d << amt;
      OpShr:   res = d >> amt;
      OpSra:   res = (d >> amt) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> amt));
      OpRol:   res = (d << amt) | (d >> (WIDTH - amt));
      OpRor:   res = (d >> amt) | (d << (WIDTH - amt));
      default: res = d;
    endcase
    return res;
  endfunction

  entry_t            in_ent;
  logic              in_oob;
  entry_t            stage_q [NSTAGE];
  entry_t            src     [NSTAGE];
  entry_t            nxt     [NSTAGE];
  logic [NSTAGE-1:0] valid_q;
  logic [NSTAGE-1:0] src_valid;
  logic [NSTAGE-1:0] adv;

  if (SHIFT_W > LG) begin : g_oob
    assign in_oob = |bus.in_shift[SHIFT_W-1:LG];
  end else begin : g_no_oob
    assign in_oob = 1'b0;
  end

  always_comb begin
    in_ent.data  = bus.in_data;
    in_ent.shamt = SHW'(bus.in_shift[LG-1:0]);
    in_ent.op    = bus.in_op;
    in_ent.oob   = in_oob;
    in_ent.sign  = bus.in_data[WIDTH-1];
  end

  always_comb begin : stage_src
    src[0]       = in_ent;
    src_valid[0] = bus.in_valid;
    for (int i = 1; i < NSTAGE; i++) begin
      src[i]       = stage_q[i-1];
      src_valid[i] = valid_q[i-1];
    end
  end

  always_comb begin : stage_shift
    for (int i = 0; i < NSTAGE; i++) begin
      nxt[i] = src[i];
      for (int l = 0; l < LEVELS_PER_STAGE; l++) begin
        if (src[i].shamt[i * LEVELS_PER_STAGE + l]) begin
          nxt[i].data = shift_level(nxt[i].data, src[i].op, src[i].sign,
                                    1 << (i * LEVELS_PER_STAGE + l));
        end
      end
    end
    // Out-of-range amounts only matter for non-rotating ops; resolve them on the way out.
    if (nxt[NSTAGE-1].oob) begin
      case (nxt[NSTAGE-1].op)
        OpShl, OpShr: nxt[NSTAGE-1].data = '0;
        OpSra:        nxt[NSTAGE-1].data = {WIDTH{nxt[NSTAGE-1].sign}};
        default:      ;
      endcase
    end
  end

  always_comb begin : stage_advance
    logic down;
    down = bus.out_ready;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | down;
      down   = adv[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (adv[i]) begin
          valid_q[i] <= src_valid[i];
          if (src_valid[i]) begin
            stage_q[i] <= nxt[i];
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[NSTAGE-1];
  assign bus.out_data  = stage_q[NSTAGE-1].data;
  assign busy          = |valid_q;
endmodule
